// File: rtl/yolo_qr_top.sv
// AXI-Stream QR accelerator: loads an 8x4 matrix of signed 16-bit elements,
// triangularises it with CORDIC-based Givens rotations and streams R back out.
module yolo_qr_top #(
  parameter int TBITS = 64,
  parameter int TBYTE = TBITS / 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             S_AXIS_MM2S_ACLK,
  input  logic             M_AXIS_S2MM_ACLK,
  input  logic             S_AXIS_MM2S_TVALID,
  output logic             S_AXIS_MM2S_TREADY,
  input  logic [TBITS-1:0] S_AXIS_MM2S_TDATA,
  input  logic [TBYTE-1:0] S_AXIS_MM2S_TKEEP,
  input  logic             S_AXIS_MM2S_TLAST,
  output logic             M_AXIS_S2MM_TVALID,
  input  logic             M_AXIS_S2MM_TREADY,
  output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
  output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
  output logic             M_AXIS_S2MM_TLAST
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_SEND} state_e;
  typedef enum logic [1:0] {PH_PREP, PH_ITER, PH_WRITE} phase_e;
  typedef logic signed [15:0] elem_t;
  typedef logic signed [19:0] acc_t;

  localparam elem_t GAIN_K = 16'sd19898;

  state_e     state_q, state_d;
  phase_e     phase_q;
  elem_t      mat_q [8][4];
  acc_t       xv_q  [4];
  acc_t       yv_q  [4];
  logic [2:0] row_r_q;
  logic [2:0] row_s_q;
  logic [2:0] row_i_q;
  logic [1:0] col_j_q;
  logic [3:0] iter_q;
  logic       skip_q;
  logic       tready_q;

  logic       in_fire, out_fire;
  logic [2:0] row_p;
  logic       pair_last, pivot_neg, pivot_y_zero, rot_pos;
  logic       unused_inputs;

  assign unused_inputs = ^{S_AXIS_MM2S_ACLK, M_AXIS_S2MM_ACLK,
                           S_AXIS_MM2S_TKEEP, S_AXIS_MM2S_TLAST};

  assign in_fire      = S_AXIS_MM2S_TVALID & tready_q;
  assign out_fire     = M_AXIS_S2MM_TVALID & M_AXIS_S2MM_TREADY;
  assign row_p        = row_i_q - 3'd1;
  assign pair_last    = (row_i_q == ({1'b0, col_j_q} + 3'd1));
  assign pivot_neg    = mat_q[row_p][col_j_q][15];
  assign pivot_y_zero = (mat_q[row_i_q][col_j_q] == '0);
  assign rot_pos      = ~yv_q[col_j_q][19];

  function automatic acc_t sext(input elem_t v);
    return acc_t'(v);
  endfunction

  // Undo the CORDIC gain (unless the rotation was skipped) and clamp to 16 bits.
  function automatic elem_t gain_sat(input acc_t v, input logic raw);
    logic signed [35:0] p;
    if (raw) p = 36'(v);
    else     p = (36'(v) * 36'(GAIN_K)) >>> 15;
    if (p > 36'sd32767)       return 16'sh7fff;
    else if (p < -36'sd32768) return 16'sh8000;
    else                      return p[15:0];
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_fire) state_d = ST_LOAD;
      ST_LOAD:    if (in_fire && row_r_q == 3'd7) state_d = ST_COMPUTE;
      ST_COMPUTE: if (phase_q == PH_WRITE && col_j_q == 2'd3 && pair_last) state_d = ST_SEND;
      ST_SEND:    if (out_fire && row_s_q == 3'd7) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the matrix store is a small register array, so it is cleared on reset
      // like any other state rather than being left to power-up contents.
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 4; c++)
          mat_q[r][c] <= '0;
      for (int c = 0; c < 4; c++) begin
        xv_q[c] <= '0;
        yv_q[c] <= '0;
      end
      phase_q  <= PH_PREP;
      row_r_q  <= '0;
      row_s_q  <= '0;
      row_i_q  <= 3'd7;
      col_j_q  <= '0;
      iter_q   <= '0;
      skip_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      tready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (in_fire) begin
            for (int c = 0; c < 4; c++)
              mat_q[row_r_q][c] <= S_AXIS_MM2S_TDATA[16*c +: 16];
            row_r_q <= row_r_q + 3'd1;
            if (row_r_q == 3'd7) begin
              col_j_q <= '0;
              row_i_q <= 3'd7;
              phase_q <= PH_PREP;
            end
          end
        end
        ST_COMPUTE: begin
          case (phase_q)
            PH_PREP: begin
              // A negative pivot is first turned by 180 degrees so CORDIC sees x >= 0.
              for (int c = 0; c < 4; c++) begin
                xv_q[c] <= pivot_neg ? -sext(mat_q[row_p][c])   : sext(mat_q[row_p][c]);
                yv_q[c] <= pivot_neg ? -sext(mat_q[row_i_q][c]) : sext(mat_q[row_i_q][c]);
              end
              // y == 0 needs no rotation; iterating anyway would turn an all-zero
              // pivot by ~100 degrees and smear the other columns for nothing.
              skip_q  <= pivot_y_zero;
              iter_q  <= '0;
              phase_q <= pivot_y_zero ? PH_WRITE : PH_ITER;
            end
            PH_ITER: begin
              for (int c = 0; c < 4; c++) begin
                if (rot_pos) begin
                  xv_q[c] <= xv_q[c] + (yv_q[c] >>> iter_q);
                  yv_q[c] <= yv_q[c] - (xv_q[c] >>> iter_q);
                end else begin
                  xv_q[c] <= xv_q[c] - (yv_q[c] >>> iter_q);
                  yv_q[c] <= yv_q[c] + (xv_q[c] >>> iter_q);
                end
              end
              iter_q <= iter_q + 4'd1;
              if (iter_q == 4'd11) phase_q <= PH_WRITE;
            end
            default: begin
              for (int c = 0; c < 4; c++) begin
                if (c >= int'(col_j_q)) begin
                  mat_q[row_p][c]   <= gain_sat(xv_q[c], skip_q);
                  mat_q[row_i_q][c] <= (c == int'(col_j_q)) ? '0 : gain_sat(yv_q[c], skip_q);
                end
              end
              if (pair_last) begin
                col_j_q <= col_j_q + 2'd1;
                row_i_q <= 3'd7;
              end else begin
                row_i_q <= row_i_q - 3'd1;
              end
              phase_q <= PH_PREP;
            end
          endcase
        end
        ST_SEND: if (out_fire) row_s_q <= row_s_q + 3'd1;
        default: ;
      endcase
    end
  end

  assign S_AXIS_MM2S_TREADY = tready_q;

  always_comb begin
    M_AXIS_S2MM_TVALID = (state_q == ST_SEND);
    M_AXIS_S2MM_TKEEP  = M_AXIS_S2MM_TVALID ? '1 : '0;
    M_AXIS_S2MM_TLAST  = M_AXIS_S2MM_TVALID && (row_s_q == 3'd7);
    M_AXIS_S2MM_TDATA  = '0;
    if (M_AXIS_S2MM_TVALID)
      for (int c = 0; c < 4; c++)
        M_AXIS_S2MM_TDATA[16*c +: 16] = mat_q[row_s_q][c];
  end

endmodule

// File: tb/tb_yolo_qr_top.sv
// Self-checking bench for yolo_qr_top: directed and random matrices compared
// against a floating-point Givens QR reference.
module tb_yolo_qr_top;

  typedef logic signed [15:0] mat_t [8][4];
  typedef real rmat_t [8][4];

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  yolo_qr_top dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .S_AXIS_MM2S_ACLK   (aclk),
    .M_AXIS_S2MM_ACLK   (aclk),
    .S_AXIS_MM2S_TVALID (s_tvalid),
    .S_AXIS_MM2S_TREADY (s_tready),
    .S_AXIS_MM2S_TDATA  (s_tdata),
    .S_AXIS_MM2S_TKEEP  (s_tkeep),
    .S_AXIS_MM2S_TLAST  (s_tlast),
    .M_AXIS_S2MM_TVALID (m_tvalid),
    .M_AXIS_S2MM_TREADY (m_tready),
    .M_AXIS_S2MM_TDATA  (m_tdata),
    .M_AXIS_S2MM_TKEEP  (m_tkeep),
    .M_AXIS_S2MM_TLAST  (m_tlast)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    bit     bad;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    bad = (tol == 0) ? (got != exp) : (diff > tol);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Ideal real-valued Givens QR in the same pair order; r >= 0 on every pivot.
  function automatic void ref_qr(input mat_t a, output rmat_t q);
    real x, y, h, cs, sn, u, v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        q[r][c] = real'(a[r][c]);
    for (int j = 0; j < 4; j++)
      for (int i = 7; i > j; i--) begin
        x = q[i-1][j];
        y = q[i][j];
        h = $sqrt(x * x + y * y);
        if (h > 0.0) begin
          cs = x / h;
          sn = y / h;
          for (int c = j; c < 4; c++) begin
            u = q[i-1][c];
            v = q[i][c];
            q[i-1][c] = cs * u + sn * v;
            q[i][c]   = cs * v - sn * u;
          end
        end
        q[i][j] = 0.0;
      end
  endfunction

  task automatic compare_result(input string name, input mat_t got, input rmat_t exp,
                                input int tol);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (r >= 4 || c < r)
          check($sformatf("%s_r%0dc%0d_zero", name, r, c), got[r][c], 0);
        else
          check($sformatf("%s_r%0dc%0d", name, r, c), got[r][c], longint'(exp[r][c]), tol);
  endtask

  task automatic send_matrix(input string name, input mat_t m);
    for (int r = 0; r < 8; r++) begin
      int w = 0;
      s_tvalid = 1'b1;
      s_tdata  = {m[r][3], m[r][2], m[r][1], m[r][0]};
      while (!s_tready && w < 50) begin
        @(negedge aclk);
        w++;
      end
      check($sformatf("%s_tready_b%0d", name, r), s_tready, 1);
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic recv_matrix(input string name, input bit toggle, output mat_t m);
    int          beats = 0;
    int          cyc = 0;
    bit          pend = 0;
    logic [63:0] held = '0;
    m = '{default: '0};
    while (beats < 8 && cyc < 2000) begin
      @(negedge aclk);
      cyc++;
      m_tready = toggle ? ~m_tready : 1'b1;
      if (pend) begin
        check($sformatf("%s_hold_b%0d", name, beats), m_tdata, held);
        pend = 0;
      end
      if (m_tvalid) begin
        if (m_tready) begin
          for (int c = 0; c < 4; c++)
            m[beats][c] = m_tdata[16*c +: 16];
          check($sformatf("%s_tkeep_b%0d", name, beats), m_tkeep, 8'hff);
          check($sformatf("%s_tlast_b%0d", name, beats), m_tlast, longint'(beats == 7));
          beats++;
        end else begin
          held = m_tdata;
          pend = 1;
        end
      end
    end
    check($sformatf("%s_beats", name), beats, 8);
    @(negedge aclk);
    m_tready = 1'b1;
    check($sformatf("%s_tvalid_after", name), m_tvalid, 0);
    check($sformatf("%s_tdata_after", name), m_tdata, 0);
    check($sformatf("%s_tkeep_after", name), m_tkeep, 0);
    check($sformatf("%s_tlast_after", name), m_tlast, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check($sformatf("%s_tready", name), s_tready, 0);
    check($sformatf("%s_tvalid", name), m_tvalid, 0);
    check($sformatf("%s_tdata", name), m_tdata, 0);
    check($sformatf("%s_tkeep", name), m_tkeep, 0);
    check($sformatf("%s_tlast", name), m_tlast, 0);
  endtask

  task automatic random_matrix(output mat_t m);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 16'(int'($urandom_range(0, 8191)) - 4096);
  endtask

  task automatic run_case(input string name, input mat_t a, input bit toggle, input int tol);
    mat_t  got;
    rmat_t exp;
    send_matrix(name, a);
    recv_matrix(name, toggle, got);
    ref_qr(a, exp);
    compare_result(name, got, exp, tol);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t  a, got;
    rmat_t exp;
    int    w, seen;

    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = 8'hff;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    aresetn  = 1'b0;

    repeat (2) @(negedge aclk);
    check_outputs_zero("reset");
    aresetn = 1'b1;
    w = 0;
    while (!s_tready && w < 2) begin
      @(negedge aclk);
      w++;
    end
    check("tready_after_reset", s_tready, 1);

    a = '{default: '0};
    for (int r = 0; r < 4; r++) a[r][r] = 16'sh1000;
    run_case("identity", a, 1'b0, 2);

    a = '{default: '0};
    for (int r = 0; r < 8; r++) a[r][0] = 16'sh0400;
    send_matrix("colvec", a);
    recv_matrix("colvec", 1'b0, got);
    check("colvec_r0c0_sqrt8", got[0][0], 2896, 3);
    ref_qr(a, exp);
    compare_result("colvec", got, exp, 3);

    a = '{default: '0};
    a[0][0] = -16'sh1000;
    send_matrix("negpiv", a);
    s_tvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_tdata = {$urandom, $urandom};
      check($sformatf("negpiv_busy_tready_%0d", k), s_tready, 0);
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
    recv_matrix("negpiv", 1'b0, got);
    check("negpiv_r0c0", got[0][0], 4096, 2);
    ref_qr(a, exp);
    compare_result("negpiv", got, exp, 2);

    random_matrix(a);
    run_case("backpressure", a, 1'b1, 80);

    random_matrix(a);
    send_matrix("abort", a);
    repeat (30) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_outputs_zero("abort_reset");
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      if (m_tvalid) seen++;
    end
    check("abort_no_beats", seen, 0);
    random_matrix(a);
    run_case("after_abort", a, 1'b0, 80);

    for (int t = 0; t < 3; t++) begin
      random_matrix(a);
      run_case($sformatf("rand%0d", t), a, t[0], 80);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
